tick_period_decoder: RTL

- Receiver end of the game's tick-rate interface.
- Watches a single-cycle tick stream from the tick generator and recovers the programmed speed value, i.e. the number of idle cycles between consecutive ticks.
- Flags when the period is stable (locked), when it changes, and when ticks stop.
- Used by the difficulty/score-display logic and as an in-system checker on the tick generator.

---
 rtl/flappy_timing_pkg.sv | 13 +
 rtl/tick_interval_counter.sv | 42 ++++
 rtl/tick_period_decoder.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/flappy_timing_pkg.sv
// rtl/flappy_timing_pkg.sv - shared timing types for the tick generator and tick period decoder
package flappy_timing_pkg;

  // Width of the speed value exchanged between the tick generator and the decoder
  localparam int SPEED_W = 27;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    LOCKED
  } decoder_state_t;

endpackage

// File: rtl/tick_interval_counter.sv
// rtl/tick_interval_counter.sv - saturating count of non-tick cycles since the last tick
module tick_interval_counter
  import flappy_timing_pkg::*;
#(
  parameter int          WIDTH = SPEED_W,
  parameter int unsigned LIMIT = 2**27 - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt,
  output logic             at_limit
);

  localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Restart on every tick or clear, otherwise count up and stick at the limit
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT_W) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt      = cnt_q;
  assign at_limit = (cnt_q == LIMIT_W);

endmodule

// File: rtl/tick_period_decoder.sv
// rtl/tick_period_decoder.sv - recovers the tick generator speed and flags lock, change and loss of ticks
module tick_period_decoder
  import flappy_timing_pkg::*;
#(
  parameter int          WIDTH      = SPEED_W,
  parameter int          LOCK_COUNT = 4,
  parameter int unsigned TIMEOUT    = 2**27 - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_in,
  input  logic             clear,
  output logic [WIDTH-1:0] speed_out,
  output logic             period_valid,
  output logic             locked,
  output logic             mismatch,
  output logic             timeout
);

  localparam logic [3:0] LOCK_RUN = 4'(LOCK_COUNT);

  decoder_state_t   state_q, state_d;
  logic [3:0]       run_q, run_d;
  logic [WIDTH-1:0] last_period_q, last_period_d;
  logic [WIDTH-1:0] speed_q, speed_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             mismatch_q, mismatch_d;
  logic             timeout_q, timeout_d;

  logic [WIDTH-1:0] cnt;
  logic             at_limit;
  logic [3:0]       run_next;

  // Clear also restarts the interval so a partial measurement is discarded
  tick_interval_counter #(
    .WIDTH (WIDTH),
    .LIMIT (TIMEOUT)
  ) u_interval (
    .clk      (clk),
    .reset    (reset),
    .clr      (clear | tick_in),
    .cnt      (cnt),
    .at_limit (at_limit)
  );

  // Next state, run tracking and registered output values
  always_comb begin
    state_d       = state_q;
    run_d         = run_q;
    last_period_d = last_period_q;
    speed_d       = speed_q;
    valid_d       = 1'b0;
    locked_d      = locked_q;
    mismatch_d    = 1'b0;
    timeout_d     = 1'b0;
    run_next      = (run_q == 4'd0 || cnt != last_period_q) ? 4'd1 : run_q + 4'd1;

    if (clear) begin
      state_d       = IDLE;
      run_d         = 4'd0;
      last_period_d = '0;
      speed_d       = '0;
      locked_d      = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tick_in) begin
            state_d = MEASURE;
            run_d   = 4'd0;
          end
        end
        MEASURE: begin
          if (tick_in) begin
            speed_d       = cnt;
            valid_d       = 1'b1;
            last_period_d = cnt;
            run_d         = run_next;
            if (run_next == LOCK_RUN) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
          end else if (at_limit) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            run_d     = 4'd0;
            speed_d   = '0;
          end
        end
        LOCKED: begin
          if (tick_in) begin
            speed_d = cnt;
            valid_d = 1'b1;
            if (cnt != last_period_q) begin
              state_d       = MEASURE;
              mismatch_d    = 1'b1;
              locked_d      = 1'b0;
              run_d         = 4'd1;
              last_period_d = cnt;
            end
          end else if (at_limit) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            run_d     = 4'd0;
            speed_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      run_q         <= 4'd0;
      last_period_q <= '0;
      speed_q       <= '0;
      valid_q       <= 1'b0;
      locked_q      <= 1'b0;
      mismatch_q    <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      run_q         <= run_d;
      last_period_q <= last_period_d;
      speed_q       <= speed_d;
      valid_q       <= valid_d;
      locked_q      <= locked_d;
      mismatch_q    <= mismatch_d;
      timeout_q     <= timeout_d;
    end
  end

  assign speed_out    = speed_q;
  assign period_valid = valid_q;
  assign locked       = locked_q;
  assign mismatch     = mismatch_q;
  assign timeout      = timeout_q;

endmodule
